mdu_ctrl: RTL

- Multi-cycle multiply/divide sequencer in the execute stage of the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E-stage decode.
- Stalls the pipeline while an iterative operation runs, then issues exactly one HI/LO write: hilo_we plus hi/lo data.
- The HI/LO register file is the sole consumer of its outputs.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/div_radix2.sv | 50 +++++
 rtl/mdu_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
//   md_op_e     - operation codes driven by E-stage decode
//   mdu_state_e - sequencer state
//   DIV_CYCLES  - restoring divide iterations (one quotient bit per cycle)
//   is_iter_op  - true for ops that stall the pipeline (MULT/MULTU/DIV/DIVU)
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // One iteration per quotient bit of a 32-bit dividend; the divider
  // datapath depends on this exact value.
  localparam int DIV_CYCLES = 32;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/div_radix2.sv
// div_radix2: unsigned iterative restoring divider, one quotient bit per step.
//   clk, rst           - clock, synchronous active-high reset
//   load               - capture dividend/divisor and clear the partial remainder
//   step               - perform one restoring iteration
//   dividend, divisor  - 32-bit unsigned operands
//   quotient, remainder- results, valid after 32 steps following load
// A zero divisor needs no special case: every trial subtraction succeeds,
// giving an all-ones quotient and the dividend as remainder.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // bit 32 of the difference is the borrow (remainder smaller than divisor).
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  // The quotient register doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= diff[32] ? rem_sh[31:0] : diff[31:0];
      quo_q <= {quo_q[30:0], ~diff[32]};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer feeding the HI/LO register file.
//   clk, rst          - clock, synchronous active-high reset
//   flushE            - E-stage flush, cancels any operation
//   start, op, a, b   - md instruction from decode (held while stall_o=1)
//   stall_o           - stall request to the hazard unit
//   busy              - sequencer not idle
//   hilo_we           - [1] write HI, [0] write LO
//   hi_wdata, lo_wdata- HI/LO write data (zero when not written)
// MTHI/MTLO write in the issue cycle. MULT*/DIV* stall for N+1 cycles and
// write HI and LO together in the following DONE cycle.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushE,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall_o,
  output logic        busy,
  output logic [1:0]  hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  mdu_state_e  state;
  logic [5:0]  cnt;
  logic [31:0] a_q;
  logic [63:0] prod_q;
  logic        is_div_q;
  logic        quo_neg_q;
  logic        rem_neg_q;
  logic        div_zero_q;

  logic        accept;
  logic        op_div;
  logic        op_signed_div;
  logic        op_signed_mul;
  logic [63:0] product;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign accept        = (state == IDLE) && start && !flushE && is_iter_op(op);
  assign op_div        = (op == MD_DIV) || (op == MD_DIVU);
  assign op_signed_div = (op == MD_DIV);
  assign op_signed_mul = (op == MD_MULT);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned multiply.
  assign product = {{32{op_signed_mul & a[31]}}, a} * {{32{op_signed_mul & b[31]}}, b};

  // The divider works on magnitudes; negating 0x80000000 yields itself,
  // which is the correct unsigned magnitude.
  assign a_mag = (op_signed_div && a[31]) ? -a : a;
  assign b_mag = (op_signed_div && b[31]) ? -b : b;

  div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && op_div),
    .step      ((state == BUSY) && is_div_q && !flushE),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  // Sequencer: latch operands on accept, count out the latency in BUSY,
  // spend exactly one cycle in DONE for the HI/LO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_q        <= '0;
      prod_q     <= '0;
      is_div_q   <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= BUSY;
            cnt        <= op_div ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);
            a_q        <= a;
            prod_q     <= product;
            is_div_q   <= op_div;
            quo_neg_q  <= op_signed_div && (a[31] ^ b[31]);
            rem_neg_q  <= op_signed_div && a[31];
            div_zero_q <= (b == 32'd0);
          end
        end
        BUSY: begin
          if (flushE) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Divide by zero returns the raw dividend, bypassing the sign fixup.
  always_comb begin
    res_hi = prod_q[63:32];
    res_lo = prod_q[31:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi = a_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_neg_q ? -rem : rem;
        res_lo = quo_neg_q ? -quo : quo;
      end
    end
  end

  // Outputs are forced low while rst is high so a reset never leaks a write.
  always_comb begin
    stall_o  = 1'b0;
    hilo_we  = 2'b00;
    hi_wdata = '0;
    lo_wdata = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (start && !flushE) begin
            if (op == MD_MTHI) begin
              hilo_we  = 2'b10;
              hi_wdata = a;
            end else if (op == MD_MTLO) begin
              hilo_we  = 2'b01;
              lo_wdata = a;
            end else if (is_iter_op(op)) begin
              stall_o = 1'b1;
            end
          end
        end
        BUSY: stall_o = !flushE;
        DONE: begin
          if (!flushE) begin
            hilo_we  = 2'b11;
            hi_wdata = res_hi;
            lo_wdata = res_lo;
          end
        end
        default: stall_o = 1'b0;
      endcase
    end
  end

  assign busy = !rst && (state != IDLE);

endmodule
